// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller for a classic 5-stage in-order core.
//   Handles three hazards in strict priority order:
//     1. data-memory wait (MEM stage not ready)  -> freeze the back end
//     2. load-use dependency between EX and ID    -> one-cycle bubble
//     3. taken branch resolved in ID              -> squash the IF/ID slot
//   A small FSM tracks consecutive memory wait cycles and enters a sticky
//   ERROR state when the wait exceeds WAIT_LIMIT; only reset leaves ERROR.
//   Stall and flush statistics counters saturate at all-ones.
//
// Parameters
//   WAIT_LIMIT  max consecutive data-memory wait cycles before timeout
//   CNT_W       width of the stall/flush statistics counters
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   synchronous, active-high
//   IDEX_MemRead  in   EX-stage instruction is a load
//   IDEX_rt       in   EX-stage load destination register
//   IFID_rs       in   ID-stage rs
//   IFID_rt       in   ID-stage rt
//   IFID_uses_rt  in   ID-stage instruction reads rt
//   branch_taken  in   branch resolved taken in ID
//   mem_req       in   MEM-stage data access in progress
//   mem_ready     in   data memory completes the access this cycle
//   PCWrite       out  PC update enable
//   IFIDWrite     out  IF/ID load enable
//   IFIDflush     out  zero the IF/ID instruction
//   IDEXflush     out  zero ID/EX control fields
//   pipe_freeze   out  hold ID/EX, EX/MEM, MEM/WB
//   mem_timeout   out  sticky timeout flag
//   stall_cnt     out  load-use stall cycle count (saturating)
//   flush_cnt     out  branch flush count (saturating)
//   state         out  0=RUN, 1=MEM_WAIT, 2=ERROR
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_rt,
    input  logic [4:0]       IFID_rs,
    input  logic [4:0]       IFID_rt,
    input  logic             IFID_uses_rt,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDflush,
    output logic             IDEXflush,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);

    // Wait counter must be able to hold WAIT_LIMIT itself.
    localparam int WCNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(WAIT_LIMIT);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERROR    = 2'd2
    } state_t;

    state_t            cur;
    logic [WCNT_W-1:0] wait_cnt;

    logic load_use;
    logic mem_wait;
    logic active;
    logic stall_inc;
    logic flush_inc;

    assign state = cur;

    // ------------------------------------------------------------------
    // Hazard detection. r0 is hardwired zero, so a load targeting it never
    // creates a real dependency.
    // ------------------------------------------------------------------
    assign load_use = IDEX_MemRead && (IDEX_rt != 5'd0) &&
                      ((IDEX_rt == IFID_rs) ||
                       (IFID_uses_rt && (IDEX_rt == IFID_rt)));

    assign mem_wait = mem_req && !mem_ready;

    // Hazard arbitration is only live outside ERROR and outside reset.
    assign active = !reset && ((cur == S_RUN) || (cur == S_MEM_WAIT));

    // A memory wait masks everything below it; a load-use bubble masks the
    // branch because the branch compare used stale operands.
    assign stall_inc = active && !mem_wait && load_use;
    assign flush_inc = active && !mem_wait && !load_use && branch_taken;

    // ------------------------------------------------------------------
    // Control outputs: purely combinational so they act this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFIDflush   = 1'b0;
        IDEXflush   = 1'b0;
        pipe_freeze = 1'b0;

        if (reset) begin
            // Front end held and squashed, back end allowed to drain zeros.
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IFIDflush   = 1'b1;
            IDEXflush   = 1'b1;
            pipe_freeze = 1'b0;
        end else begin
            case (cur)
                S_RUN, S_MEM_WAIT: begin
                    if (mem_wait) begin
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        pipe_freeze = 1'b1;
                    end else if (load_use) begin
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEXflush   = 1'b1;
                    end else if (branch_taken) begin
                        IFIDflush   = 1'b1;
                    end
                end
                default: begin
                    // ERROR (and the unused encoding): stop everything.
                    PCWrite     = 1'b0;
                    IFIDWrite   = 1'b0;
                    IFIDflush   = 1'b1;
                    IDEXflush   = 1'b1;
                    pipe_freeze = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM, wait counter, timeout flag and statistics counters.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= S_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            case (cur)
                S_RUN: begin
                    // A same-cycle ready never leaves RUN.
                    if (mem_wait) begin
                        cur      <= S_MEM_WAIT;
                        wait_cnt <= WCNT_W'(1);
                    end
                end
                S_MEM_WAIT: begin
                    if (!mem_wait) begin
                        cur      <= S_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_MAX) begin
                        cur         <= S_ERROR;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                S_ERROR: begin
                    mem_timeout <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: treat as a fault.
                    cur         <= S_ERROR;
                    mem_timeout <= 1'b1;
                end
            endcase

            if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int WL    = 255;
    localparam int CW    = 16;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          IDEX_MemRead;
    logic [4:0]    IDEX_rt;
    logic [4:0]    IFID_rs;
    logic [4:0]    IFID_rt;
    logic          IFID_uses_rt;
    logic          branch_taken;
    logic          mem_req;
    logic          mem_ready;
    logic          PCWrite, IFIDWrite, IFIDflush, IDEXflush, pipe_freeze;
    logic          mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [1:0]    state;

    hazard_ctrl #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_rt(IDEX_rt),
        .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_uses_rt(IFID_uses_rt),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDflush(IFIDflush),
        .IDEXflush(IDEXflush), .pipe_freeze(pipe_freeze),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: wait length so far, error flag, plain integer counts.
    int m_wait  = 0;
    bit m_err   = 0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_lu();
        return IDEX_MemRead && IDEX_rt != 0 &&
               (IDEX_rt == IFID_rs || (IFID_uses_rt && IDEX_rt == IFID_rt));
    endfunction

    function automatic bit m_mw();
        return mem_req && !mem_ready;
    endfunction

    // {PCWrite, IFIDWrite, IFIDflush, IDEXflush, pipe_freeze}
    function automatic logic [4:0] m_outs();
        if (reset)        return 5'b00110;
        else if (m_err)   return 5'b00111;
        else if (m_mw())  return 5'b00001;
        else if (m_lu())  return 5'b00010;
        else if (branch_taken) return 5'b11100;
        else              return 5'b11000;
    endfunction

    function automatic logic [4:0] dut_outs();
        return {PCWrite, IFIDWrite, IFIDflush, IDEXflush, pipe_freeze};
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_wait = 0; m_err = 0; m_stall = 0; m_flush = 0;
        end else if (!m_err) begin
            if (m_mw()) begin
                if (m_wait == WL) m_err = 1;
                else m_wait++;
            end else begin
                m_wait = 0;
                if (m_lu()) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
                else if (branch_taken) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            end
        end
    endtask

    // Compare everything against the model mid-cycle, then take one edge.
    task automatic cycle();
        logic [1:0] es;
        @(negedge clk);
        es = m_err ? 2'd2 : (m_wait > 0 ? 2'd1 : 2'd0);
        chk("outs",    32'(dut_outs()), 32'(m_outs()));
        chk("state",   32'(state), 32'(es));
        chk("timeout", 32'(mem_timeout), 32'(m_err));
        chk("stall",   32'(stall_cnt), 32'(m_stall));
        chk("flush",   32'(flush_cnt), 32'(m_flush));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        IDEX_MemRead = 0; IDEX_rt = 0; IFID_rs = 0; IFID_rt = 0;
        IFID_uses_rt = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        cycle();
        reset = 0;
    endtask

    typedef struct {
        string      nm;
        logic       mr;
        logic [4:0] ert, rs, rt;
        logic       urt, br, req, rdy;
        logic [4:0] outs;   // {PCW, IFIDW, IFIDflush, IDEXflush, freeze}
        int         dstall;
        int         dflush;
    } vec_t;

    vec_t vt[11];

    initial begin
        vt[0]  = '{"idle",        0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 0};
        vt[1]  = '{"lu_rs",       1, 8, 8, 0, 0, 0, 0, 0, 5'b00010, 1, 0};
        vt[2]  = '{"lu_r0",       1, 0, 0, 0, 1, 0, 0, 0, 5'b11000, 0, 0};
        vt[3]  = '{"rt_unused",   1, 9, 3, 9, 0, 0, 0, 0, 5'b11000, 0, 0};
        vt[4]  = '{"lu_rt",       1, 9, 3, 9, 1, 0, 0, 0, 5'b00010, 1, 0};
        vt[5]  = '{"no_load",     0, 8, 8, 8, 1, 0, 0, 0, 5'b11000, 0, 0};
        vt[6]  = '{"branch",      0, 0, 0, 0, 0, 1, 0, 0, 5'b11100, 0, 1};
        vt[7]  = '{"lu_over_br",  1, 8, 8, 0, 0, 1, 0, 0, 5'b00010, 1, 0};
        vt[8]  = '{"mw_over_all", 1, 8, 8, 0, 0, 1, 1, 0, 5'b00001, 0, 0};
        vt[9]  = '{"rdy_lu",      1, 5, 5, 0, 0, 0, 1, 1, 5'b00010, 1, 0};
        vt[10] = '{"rdy_br",      0, 0, 0, 0, 0, 1, 1, 1, 5'b11100, 0, 1};

        idle_inputs();
        reset = 1;
        #1;
        chk("rst_outs", 32'(dut_outs()), 32'h06);
        do_reset();
        chk("rst_state", 32'(state), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        chk("rst_flush", 32'(flush_cnt), 0);
        chk("rst_tmo",   32'(mem_timeout), 0);

        // Table-driven single-cycle vectors, each from a clean reset.
        for (int i = 0; i < 11; i++) begin
            do_reset();
            IDEX_MemRead = vt[i].mr; IDEX_rt = vt[i].ert;
            IFID_rs = vt[i].rs; IFID_rt = vt[i].rt; IFID_uses_rt = vt[i].urt;
            branch_taken = vt[i].br; mem_req = vt[i].req; mem_ready = vt[i].rdy;
            #1;
            chk({vt[i].nm, "_outs"}, 32'(dut_outs()), 32'(vt[i].outs));
            cycle();
            chk({vt[i].nm, "_stall"}, 32'(stall_cnt), 32'(vt[i].dstall));
            chk({vt[i].nm, "_flush"}, 32'(flush_cnt), 32'(vt[i].dflush));
            chk({vt[i].nm, "_state"}, 32'(state), (vt[i].req && !vt[i].rdy) ? 1 : 0);
            idle_inputs();
        end

        // Memory wait of three cycles, then ready.
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_state", 32'(state), (i == 0) ? 0 : 1);
            chk("mw_freeze", 32'(pipe_freeze), 1);
            cycle();
        end
        mem_ready = 1;
        #1;
        chk("mw_rdy_freeze", 32'(pipe_freeze), 0);
        cycle();
        chk("mw_done_state", 32'(state), 0);
        idle_inputs();

        // Timeout: WAIT_LIMIT+1 edges of continuous wait.
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < WL + 1; i++) cycle();
        chk("tmo_state", 32'(state), 2);
        chk("tmo_flag",  32'(mem_timeout), 1);
        mem_ready = 1; branch_taken = 1; IDEX_MemRead = 1; IDEX_rt = 4; IFID_rs = 4;
        cycle(); cycle();
        chk("tmo_sticky_state", 32'(state), 2);
        chk("tmo_sticky_flag",  32'(mem_timeout), 1);
        chk("tmo_outs", 32'(dut_outs()), 32'h07);
        chk("tmo_cnt_hold", 32'({stall_cnt, flush_cnt}), 0);
        idle_inputs();
        do_reset();
        chk("tmo_rst_state", 32'(state), 0);
        chk("tmo_rst_flag",  32'(mem_timeout), 0);
        chk("tmo_rst_cnts",  32'({stall_cnt, flush_cnt}), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 99) == 0);
            IDEX_MemRead = $urandom_range(0, 1);
            IDEX_rt      = 5'($urandom_range(0, 3));
            IFID_rs      = 5'($urandom_range(0, 3));
            IFID_rt      = 5'($urandom_range(0, 3));
            IFID_uses_rt = $urandom_range(0, 1);
            branch_taken = $urandom_range(0, 1);
            mem_req      = ($urandom_range(0, 3) == 0);
            mem_ready    = $urandom_range(0, 1);
            cycle();
        end
        reset = 0;
        idle_inputs();

        // Saturation: bring flush_cnt to 0xFFFE, then three more flushes.
        do_reset();
        branch_taken = 1;
        for (int i = 0; i < CMAX - 1; i++) begin
            @(posedge clk);
            model_edge();
            #1;
        end
        chk("sat_pre", 32'(flush_cnt), 32'hFFFE);
        for (int i = 0; i < 3; i++) cycle();
        chk("sat_post", 32'(flush_cnt), 32'hFFFF);
        idle_inputs();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
